rans_enc_ctrl: RTL and testbench
================================

// Module: rans_enc_ctrl
// PURPOSE
//  Sequencer for the rANS encoder. Loads the 2^SYMBOL_WIDTH-entry frequency table from a host beat stream.
//  Cumulative frequencies are computed on the fly and the table sum is checked.
//  It then gates a block of symbols from upstream into the encoder and issues restart to flush the state.
//  Sits between host/DMA and the encoder's freq_wr_i/freq_addr_i/freq_i/cum_freq_i/symb_i/valid_i/ready_o/restart_i.
// PARAMETERS
//  RESOLUTION    10  probability resolution bits; table must sum to 2^RESOLUTION
//  SYMBOL_WIDTH  8   symbol bits; table depth 2^SYMBOL_WIDTH
//  LEN_WIDTH     16  block-length counter width
// PORTS
//  clk_i            in   1           clock, all logic posedge
//  rst_i            in   1           synchronous active-high reset
//  start_i          in   1           start a job (sampled in IDLE only)
//  reload_i         in   1           with start_i: 1 = load table first, 0 = reuse loaded table
//  blk_len_i        in   LEN_WIDTH   symbols in block (sampled with start_i)
//  cfg_valid_i      in   1           frequency beat valid
//  cfg_ready_o      out  1           frequency beat accepted when valid&ready
//  cfg_freq_i       in   RESOLUTION  frequency of next symbol (index order 0..2^SW-1)
//  s_valid_i        in   1           upstream symbol valid
//  s_ready_o        out  1           upstream symbol ready
//  s_symb_i         in   SYMBOL_WIDTH upstream symbol
//  enc_freq_wr_o    out  1           table write strobe to encoder
//  enc_freq_addr_o  out  SYMBOL_WIDTH table write address
//  enc_freq_o       out  RESOLUTION  table write frequency
//  enc_cum_freq_o   out  RESOLUTION  table write cumulative frequency (exclusive prefix sum)
//  enc_valid_o      out  1           symbol valid to encoder
//  enc_ready_i      in   1           encoder ready_o
//  enc_symb_o       out  SYMBOL_WIDTH symbol to encoder
//  enc_restart_o    out  1           encoder restart/flush pulse
//  busy_o           out  1           state != IDLE
//  done_o           out  1           one-cycle pulse at job completion
//  err_o            out  1           sticky: table sum bad or run requested with no valid table; cleared by start_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; acc, index, counters, tbl_ok cleared. Reset mid-job aborts at once, no restart pulse.
//  States: IDLE -> LOAD -> CHECK -> RUN -> FLUSH -> DONE -> IDLE.
//  IDLE: start_i: clear err_o, latch blk_len. Target state:
//   reload_i=1 -> LOAD (acc=0, idx=0, tbl_ok=0).
//   reload_i=0 & tbl_ok -> RUN (blk_len=0 -> FLUSH).
//   reload_i=0 & !tbl_ok -> err_o=1, stay IDLE.
//  LOAD: cfg_ready_o=1. Per accepted beat, the next cycle drives a registered 1-cycle enc_freq_wr_o.
//   Write fields: addr=idx, freq=beat, cum=acc[RESOLUTION-1:0] (before add).
//   Then acc+=beat, idx++. acc is RESOLUTION+1 bits, saturating at 2^(RESOLUTION+1)-1.
//   Beat with idx=2^SW-1 -> CHECK; cfg_ready_o=0 from the cycle after.
//  CHECK (1 cycle): acc==2^RESOLUTION -> tbl_ok=1; next RUN, or FLUSH if blk_len==0.
//   Otherwise err_o=1, -> IDLE; no done_o, no restart.
//  RUN: combinational pass-through.
//   enc_valid_o=s_valid_i; s_ready_o=enc_ready_i; enc_symb_o=s_symb_i.
//   Each transfer (s_valid_i&enc_ready_i) increments cnt. Transfer with cnt==blk_len-1 -> FLUSH.
//   Outside RUN, enc_valid_o=0 and s_ready_o=0, so no symbol beyond blk_len is ever taken.
//  FLUSH: enc_restart_o=1 for exactly the first FLUSH cycle (registered).
//   Stay until enc_ready_i==1 on a cycle after the pulse; then -> DONE.
//  DONE (1 cycle): done_o=1, -> IDLE. tbl_ok kept for reuse.
//  start_i outside IDLE ignored; cfg beats outside LOAD not accepted.
// TESTING
//  Uniform reload, all 256 freq=4, continuous valid:
//   256 write strobes; addr 5 carries cum=20; CHECK passes; tbl_ok=1.
//  Bad table, 255x4 then 3 (sum 1023):
//   err_o=1, back to IDLE, no enc_valid_o, no restart, no done_o.
//  RUN blk_len=3, enc_ready_i toggles 1,0,1,0,1:
//   exactly 3 symbols forwarded in order; 4th s_valid_i not accepted.
//   Restart pulse 1 cycle after 3rd transfer; done_o once after enc_ready_i returns.
//  reload_i=0 after good load, blk_len=0:
//   no LOAD, restart pulse, done_o; reload_i=0 after reset gives err_o=1.
//  Reset asserted mid-LOAD at idx=100:
//   next cycle all outputs 0, IDLE, tbl_ok=0; fresh reload works.
//  start_i during RUN: ignored, blk_len unchanged.

Source files
------------

// File: rtl/rans_enc_ctrl.sv
// rans_enc_ctrl
//   Sequencer in front of a rANS encoder. A job optionally loads the
//   2^SYMBOL_WIDTH-entry frequency table from a host beat stream, writing
//   each entry to the encoder together with its exclusive prefix sum. Once
//   every entry is in, the table total is checked against 2^RESOLUTION.
//   A block of blk_len symbols is then passed from upstream to the encoder.
//   Finally a restart pulse flushes the encoder state.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, reload_i, blk_len_i job request (sampled in IDLE only)
//   cfg_valid_i/cfg_ready_o/cfg_freq_i   frequency beat stream (index order)
//   s_valid_i/s_ready_o/s_symb_i         upstream symbol stream
//   enc_freq_wr_o/enc_freq_addr_o/enc_freq_o/enc_cum_freq_o  table write
//   enc_valid_o/enc_ready_i/enc_symb_o   symbol stream to encoder
//   enc_restart_o                encoder flush pulse
//   busy_o, done_o, err_o        job status
//   state_o                      current FSM state (debug)
//
// Handshakes: every stream moves one item on a rising edge where its valid
// and ready are both high. valid never depends on ready inside this block.
// ready is asserted only in the state that consumes that stream: cfg in
// LOAD, symbols in RUN. Items offered in any other state are not taken.
module rans_enc_ctrl #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    reload_i,
  input  logic [LEN_WIDTH-1:0]    blk_len_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [RESOLUTION-1:0]   cfg_freq_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [SYMBOL_WIDTH-1:0] s_symb_i,
  output logic                    enc_freq_wr_o,
  output logic [SYMBOL_WIDTH-1:0] enc_freq_addr_o,
  output logic [RESOLUTION-1:0]   enc_freq_o,
  output logic [RESOLUTION-1:0]   enc_cum_freq_o,
  output logic                    enc_valid_o,
  input  logic                    enc_ready_i,
  output logic [SYMBOL_WIDTH-1:0] enc_symb_o,
  output logic                    enc_restart_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int AW = RESOLUTION + 1;
  localparam logic [AW-1:0]           ACC_MAX    = '1;
  localparam logic [AW-1:0]           ACC_TARGET = {1'b1, {RESOLUTION{1'b0}}};
  localparam logic [SYMBOL_WIDTH-1:0] IDX_LAST   = '1;

  state_t                  state;
  logic [AW-1:0]           acc;
  logic [AW:0]             acc_sum;
  logic [AW-1:0]           acc_next;
  logic [SYMBOL_WIDTH-1:0] idx;
  logic [LEN_WIDTH-1:0]    blk_len;
  logic [LEN_WIDTH-1:0]    cnt;
  logic                    tbl_ok;
  logic                    xfer;

  // One extra accumulator bit lets an over-full table be seen. Saturation
  // keeps a long run of large beats from wrapping back to a legal total.
  assign acc_sum  = {1'b0, acc} + {2'b00, cfg_freq_i};
  assign acc_next = acc_sum[AW] ? ACC_MAX : acc_sum[AW-1:0];

  // The symbol path is combinational so RUN adds no latency or bubbles.
  assign xfer        = (state == S_RUN) && s_valid_i && enc_ready_i;
  assign cfg_ready_o = (state == S_LOAD);
  assign s_ready_o   = (state == S_RUN) && enc_ready_i;
  assign enc_valid_o = (state == S_RUN) && s_valid_i;
  assign enc_symb_o  = (state == S_RUN) ? s_symb_i : '0;
  assign busy_o      = (state != S_IDLE);
  assign state_o     = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      acc             <= '0;
      idx             <= '0;
      blk_len         <= '0;
      cnt             <= '0;
      tbl_ok          <= 1'b0;
      enc_freq_wr_o   <= 1'b0;
      enc_freq_addr_o <= '0;
      enc_freq_o      <= '0;
      enc_cum_freq_o  <= '0;
      enc_restart_o   <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      // Pulse outputs default low and are raised only on their event.
      enc_freq_wr_o <= 1'b0;
      enc_restart_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_o   <= 1'b0;
            blk_len <= blk_len_i;
            cnt     <= '0;
            if (reload_i) begin
              acc    <= '0;
              idx    <= '0;
              tbl_ok <= 1'b0;
              state  <= S_LOAD;
            end else if (tbl_ok) begin
              if (blk_len_i == '0) begin
                enc_restart_o <= 1'b1;
                state         <= S_FLUSH;
              end else begin
                state <= S_RUN;
              end
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (cfg_valid_i) begin
            enc_freq_wr_o   <= 1'b1;
            enc_freq_addr_o <= idx;
            enc_freq_o      <= cfg_freq_i;
            enc_cum_freq_o  <= acc[RESOLUTION-1:0];
            acc             <= acc_next;
            idx             <= idx + SYMBOL_WIDTH'(1);
            if (idx == IDX_LAST) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (acc == ACC_TARGET) begin
            tbl_ok <= 1'b1;
            if (blk_len == '0) begin
              enc_restart_o <= 1'b1;
              state         <= S_FLUSH;
            end else begin
              state <= S_RUN;
            end
          end else begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (xfer) begin
            cnt <= cnt + LEN_WIDTH'(1);
            if (cnt == blk_len - LEN_WIDTH'(1)) begin
              enc_restart_o <= 1'b1;
              state         <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The restart register is high only in the first FLUSH cycle.
          // A ready seen during the pulse itself does not count.
          if (!enc_restart_o && enc_ready_i) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rans_enc_ctrl.sv
// tb_rans_enc_ctrl
//   Directed bench for rans_enc_ctrl. Expected table writes and forwarded
//   symbols are queued from the stimulus side. A per-cycle monitor pops and
//   compares them when the DUT produces them. Pulse counts and timing are
//   checked after each job.
module tb_rans_enc_ctrl;
  localparam int R  = 10;
  localparam int SW = 8;
  localparam int LW = 16;
  localparam int WW = SW + 2 * R;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, reload_i;
  logic [LW-1:0] blk_len_i;
  logic          cfg_valid_i, cfg_ready_o;
  logic [R-1:0]  cfg_freq_i;
  logic          s_valid_i, s_ready_o;
  logic [SW-1:0] s_symb_i;
  logic          enc_freq_wr_o;
  logic [SW-1:0] enc_freq_addr_o;
  logic [R-1:0]  enc_freq_o, enc_cum_freq_o;
  logic          enc_valid_o, enc_ready_i;
  logic [SW-1:0] enc_symb_o;
  logic          enc_restart_o, busy_o, done_o, err_o;
  logic [2:0]    state_o;

  rans_enc_ctrl #(.RESOLUTION(R), .SYMBOL_WIDTH(SW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .reload_i(reload_i),
    .blk_len_i(blk_len_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_freq_i(cfg_freq_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_symb_i(s_symb_i), .enc_freq_wr_o(enc_freq_wr_o),
    .enc_freq_addr_o(enc_freq_addr_o), .enc_freq_o(enc_freq_o),
    .enc_cum_freq_o(enc_cum_freq_o), .enc_valid_o(enc_valid_o),
    .enc_ready_i(enc_ready_i), .enc_symb_o(enc_symb_o),
    .enc_restart_o(enc_restart_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .state_o(state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [WW-1:0] wr_exp_q[$];
  logic [SW-1:0] sym_exp_q[$];

  int   m_idx, m_acc;
  int   wr_cnt, xfer_cnt, valid_cnt, restart_cnt, done_cnt;
  int   restart_cyc, done_cyc, cum5;
  logic load_seen, beat_acc, xfer_now;
  int   tbl[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0; xfer_cnt = 0; valid_cnt = 0; restart_cnt = 0; done_cnt = 0;
    restart_cyc = -1; done_cyc = -1; cum5 = -1; load_seen = 1'b0;
  endtask

  // Samples the DUT mid-cycle, away from the active edge.
  task automatic monitor();
    logic [WW-1:0] e;
    beat_acc = cfg_valid_i && cfg_ready_o;
    xfer_now = enc_valid_o && enc_ready_i;
    if (xfer_now || (s_valid_i && s_ready_o))
      check("xfer_hs", 32'(s_valid_i && s_ready_o), 32'(xfer_now));
    if (enc_freq_wr_o) begin
      wr_cnt++;
      if (enc_freq_addr_o == SW'(5)) cum5 = int'(enc_cum_freq_o);
      if (wr_exp_q.size() == 0) check("wr_unexp", 32'(enc_freq_wr_o), 32'(0));
      else check("wr", 32'({enc_freq_addr_o, enc_freq_o, enc_cum_freq_o}),
                 32'(wr_exp_q.pop_front()));
    end
    if (xfer_now) begin
      xfer_cnt++;
      if (sym_exp_q.size() == 0) check("sym_unexp", 32'(enc_valid_o), 32'(0));
      else check("sym", 32'(enc_symb_o), 32'(sym_exp_q.pop_front()));
    end
    if (enc_valid_o) valid_cnt++;
    if (enc_restart_o) begin restart_cnt++; restart_cyc = cyc; end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (state_o == ST_LOAD) load_seen = 1'b1;
    if (beat_acc) begin
      e = {SW'(m_idx), cfg_freq_i, R'(m_acc)};
      wr_exp_q.push_back(e);
      m_acc = m_acc + int'(cfg_freq_i);
      if (m_acc > 2047) m_acc = 2047;
      m_idx++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic rl, input int len);
    start_i = 1'b1; reload_i = rl; blk_len_i = LW'(len);
    if (rl) begin m_idx = 0; m_acc = 0; end
    tick();
    start_i = 1'b0; reload_i = 1'b0;
  endtask

  task automatic send_table(input int n, input logic gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cfg_valid_i = 1'b0;
        tick();
      end
      cfg_valid_i = 1'b1;
      cfg_freq_i  = R'(tbl[i]);
      g = 0;
      do begin tick(); g++; end while (!beat_acc && g < 50);
      if (!beat_acc) check("beat_timeout", 32'(beat_acc), 32'(1));
    end
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag, input int max);
    int g = 0;
    while (state_o !== s && g < max) begin tick(); g++; end
    check(tag, 32'(state_o), 32'(s));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [SW-1:0] syms[4];
    int k, base, a, b, d;
    int pat[12] = '{1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1};

    rst = 1'b1; start_i = 1'b0; reload_i = 1'b0; blk_len_i = '0;
    cfg_valid_i = 1'b1; cfg_freq_i = '1; s_valid_i = 1'b1; s_symb_i = 8'hA5;
    enc_ready_i = 1'b1;
    m_idx = 0; m_acc = 0;
    clear_stats();
    repeat (3) tick();

    // Reset state, with busy inputs held high to prove gating.
    check("rst_cfg_ready", 32'(cfg_ready_o), 0);
    check("rst_s_ready", 32'(s_ready_o), 0);
    check("rst_enc_valid", 32'(enc_valid_o), 0);
    check("rst_enc_symb", 32'(enc_symb_o), 0);
    check("rst_wr", 32'({enc_freq_wr_o, enc_freq_addr_o, enc_freq_o, enc_cum_freq_o}), 0);
    check("rst_status", 32'({enc_restart_o, busy_o, done_o, err_o}), 0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    rst = 1'b0; cfg_valid_i = 1'b0; s_valid_i = 1'b0; s_symb_i = '0;
    tick();

    // No table yet: a reuse request must flag an error and stay idle.
    start_job(1'b0, 5);
    check("a_err", 32'(err_o), 1);
    check("a_state", 32'(state_o), 32'(ST_IDLE));

    // Uniform table, continuous beats, empty block.
    for (int i = 0; i < 256; i++) tbl[i] = 4;
    clear_stats();
    s_valid_i = 1'b1; s_symb_i = 8'h3C;
    start_job(1'b1, 0);
    check("b_err_clr", 32'(err_o), 0);
    check("b_state", 32'(state_o), 32'(ST_LOAD));
    send_table(256, 1'b0);
    wait_state(ST_IDLE, "b_idle", 20);
    check("b_wr_cnt", 32'(wr_cnt), 256);
    check("b_cum5", 32'(cum5), 20);
    check("b_wr_q", 32'(wr_exp_q.size()), 0);
    check("b_restart", 32'(restart_cnt), 1);
    check("b_done", 32'(done_cnt), 1);
    check("b_valid", 32'(valid_cnt), 0);
    check("b_err", 32'(err_o), 0);

    // Reuse with an empty block: no LOAD, just flush and done.
    clear_stats();
    start_job(1'b0, 0);
    check("c_state", 32'(state_o), 32'(ST_FLUSH));
    wait_state(ST_IDLE, "c_idle", 20);
    check("c_load", 32'(load_seen), 0);
    check("c_restart", 32'(restart_cnt), 1);
    check("c_done", 32'(done_cnt), 1);
    check("c_wr_cnt", 32'(wr_cnt), 0);

    // Table one short of full: error, no run, no flush, no done.
    tbl[255] = 3;
    clear_stats();
    start_job(1'b1, 2);
    send_table(256, 1'b1);
    wait_state(ST_IDLE, "d_idle", 10);
    check("d_err", 32'(err_o), 1);
    check("d_restart", 32'(restart_cnt), 0);
    check("d_done", 32'(done_cnt), 0);
    check("d_valid", 32'(valid_cnt), 0);
    check("d_wr_cnt", 32'(wr_cnt), 256);

    // Random legal table, blk_len=3 under a toggling encoder ready.
    for (int i = 0; i < 256; i++) tbl[i] = 4;
    repeat (300) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, tbl[a]));
      if (tbl[b] + d <= 1023) begin tbl[a] -= d; tbl[b] += d; end
    end
    for (int i = 0; i < 4; i++) syms[i] = SW'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) sym_exp_q.push_back(syms[i]);
    clear_stats();
    enc_ready_i = 1'b0; s_valid_i = 1'b1; s_symb_i = syms[0]; k = 0;
    start_job(1'b1, 3);
    send_table(256, 1'b1);
    wait_state(ST_RUN, "e_run", 10);
    check("e_err", 32'(err_o), 0);
    base = cyc;
    for (int c = 0; c < 12; c++) begin
      enc_ready_i = pat[c][0];
      tick();
      if (xfer_now && k < 3) begin k++; s_symb_i = syms[k]; end
    end
    check("e_xfer_cnt", 32'(xfer_cnt), 3);
    check("e_sym_q", 32'(sym_exp_q.size()), 0);
    check("e_restart_cnt", 32'(restart_cnt), 1);
    check("e_restart_cyc", 32'(restart_cyc), 32'(base + 5));
    check("e_done_cnt", 32'(done_cnt), 1);
    check("e_done_cyc", 32'(done_cyc), 32'(base + 8));
    check("e_s_ready_idle", 32'(s_ready_o), 0);

    // A start request during RUN must not change the block length.
    for (int i = 0; i < 3; i++) syms[i] = SW'($urandom_range(0, 255));
    for (int i = 0; i < 2; i++) sym_exp_q.push_back(syms[i]);
    clear_stats();
    enc_ready_i = 1'b0; s_symb_i = syms[0]; k = 0;
    start_job(1'b0, 2);
    check("f_state", 32'(state_o), 32'(ST_RUN));
    start_i = 1'b1; reload_i = 1'b1; blk_len_i = LW'(100);
    tick();
    start_i = 1'b0; reload_i = 1'b0;
    check("f_state_hold", 32'(state_o), 32'(ST_RUN));
    enc_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (xfer_now && k < 2) begin k++; s_symb_i = syms[k]; end
    end
    check("f_xfer_cnt", 32'(xfer_cnt), 2);
    check("f_done", 32'(done_cnt), 1);
    check("f_load", 32'(load_seen), 0);

    // Reset in the middle of a load, then a full reload.
    for (int i = 0; i < 256; i++) tbl[i] = 4;
    clear_stats();
    start_job(1'b1, 0);
    send_table(100, 1'b0);
    rst = 1'b1;
    tick();
    check("g_wr", 32'({enc_freq_wr_o, enc_freq_addr_o, enc_freq_o, enc_cum_freq_o}), 0);
    check("g_status", 32'({enc_restart_o, busy_o, done_o, err_o, cfg_ready_o}), 0);
    check("g_state", 32'(state_o), 32'(ST_IDLE));
    check("g_wr_q", 32'(wr_exp_q.size()), 0);
    rst = 1'b0;
    wr_exp_q.delete();
    start_job(1'b0, 4);
    check("g_no_tbl_err", 32'(err_o), 1);
    syms[0] = 8'h5A;
    sym_exp_q.push_back(syms[0]);
    s_symb_i = syms[0];
    clear_stats();
    start_job(1'b1, 1);
    send_table(256, 1'b0);
    wait_state(ST_IDLE, "g_idle", 20);
    check("g_wr_cnt", 32'(wr_cnt), 256);
    check("g_xfer", 32'(xfer_cnt), 1);
    check("g_done", 32'(done_cnt), 1);
    check("g_err", 32'(err_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
